// File: rtl/pe_writeback.sv
// pe_writeback: packs PE result bytes into 32-bit words, one word per
// output line, queues them in a small FIFO and writes them to the output
// memory with a req/ack handshake.
// Optional build macro: PE_WB_SAT_EN (saturate lane bytes at 255 instead
// of truncating res_data to its low byte).
module pe_writeback #(
  parameter int unsigned NUM_LINES  = 42,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  BASE_ADR   = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  input  logic        line_end,
  output logic        mem_req,
  output logic [7:0]  mem_adr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        full,
  output logic        ovf,
  output logic        done
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [7:0]    LAST_LINE = 8'(NUM_LINES);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_DONE
  } state_e;

  state_e state_q, state_d;

  // Packer state
  logic [3:0][7:0] lanes_q, lanes_d, lanes_pk;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      lane_byte;
  logic            lane_drop;

  // FIFO state
  logic [31:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     push_word;
  logic            push_req, push, pop, word_drop, full_w;

  // Run bookkeeping
  logic [7:0]      wr_cnt_q, wr_cnt_d, wr_cnt_inc;
  logic            ovf_q, ovf_d;
  logic            run_q, run_d;

`ifdef PE_WB_SAT_EN
  assign lane_byte = (res_data > 16'd255) ? 8'hFF : res_data[7:0];
`else
  logic unused_res_hi;
  assign unused_res_hi = ^res_data[15:8];
  assign lane_byte     = res_data[7:0];
`endif

  assign full_w     = (count_q == DEPTH_C);
  assign pop        = (state_q == W_REQ) && mem_ack && !start;
  assign push_req   = line_end && !start;
  assign push       = push_req && (!full_w || pop);
  assign word_drop  = push_req && full_w && !pop;
  assign wr_cnt_inc = wr_cnt_q + 8'd1;

  // Packer: place the byte first, then snapshot for a same-cycle line_end,
  // then clear; start discards everything.
  always_comb begin
    lanes_d   = lanes_q;
    cnt_d     = cnt_q;
    lane_drop = 1'b0;
    if (res_valid) begin
      if (cnt_q < 3'd4) begin
        lanes_d[cnt_q[1:0]] = lane_byte;
        cnt_d               = cnt_q + 3'd1;
      end else begin
        lane_drop = 1'b1;
      end
    end
    lanes_pk  = lanes_d;
    push_word = {lanes_pk[3], lanes_pk[2], lanes_pk[1], lanes_pk[0]};
    if (line_end) begin
      lanes_d = '0;
      cnt_d   = '0;
    end
    if (start) begin
      lanes_d   = '0;
      cnt_d     = '0;
      lane_drop = 1'b0;
    end
  end

  // Bookkeeping next-state: FIFO occupancy, write counter, sticky error, run flag
  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_cnt_d = pop ? wr_cnt_inc : wr_cnt_q;
    ovf_d    = ovf_q | lane_drop | word_drop;
    run_d    = run_q;
    if (state_d == W_DONE) begin
      run_d = 1'b0;
    end
    if (start) begin
      count_d  = '0;
      wr_cnt_d = '0;
      ovf_d    = 1'b0;
      run_d    = 1'b1;
    end
  end

  // Packer, FIFO pointers and run bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q  <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_cnt_q <= '0;
      ovf_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      lanes_q  <= lanes_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      wr_cnt_q <= wr_cnt_d;
      ovf_q    <= ovf_d;
      run_q    <= run_d;
      if (start) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // FIFO storage; contents are only observed while non-empty, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_word;
    end
  end

  // Writer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Writer next-state and registered-state output decode
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_wdata = '0;
    mem_adr   = BASE_ADR + wr_cnt_q;
    full      = full_w;
    ovf       = ovf_q;
    done      = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (run_q && (count_q != '0)) begin
          state_d = W_REQ;
        end
      end
      W_REQ: begin
        mem_req   = 1'b1;
        mem_wdata = fifo_q[rd_ptr_q];
        if (mem_ack) begin
          if (wr_cnt_inc == LAST_LINE) begin
            state_d = W_DONE;
          end else if ((count_q > CW'(1)) || push) begin
            state_d = W_REQ;
          end else begin
            state_d = W_IDLE;
          end
        end
      end
      W_DONE: begin
        done    = 1'b1;
        state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
    if (start) begin
      state_d = W_IDLE;
    end
  end

endmodule

// File: tb/tb_pe_writeback.sv
// Directed bench for pe_writeback (NUM_LINES=3, FIFO_DEPTH=4, BASE_ADR=0x10).
module tb_pe_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, res_valid, line_end, mem_ack;
  logic [15:0] res_data;
  logic        mem_req, full, ovf, done;
  logic [7:0]  mem_adr;
  logic [31:0] mem_wdata;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  pe_writeback #(
    .NUM_LINES (3),
    .FIFO_DEPTH(4),
    .BASE_ADR  (8'h10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .res_valid(res_valid),
    .res_data (res_data),
    .line_end (line_end),
    .mem_req  (mem_req),
    .mem_adr  (mem_adr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .full     (full),
    .ovf      (ovf),
    .done     (done)
  );

  typedef struct {
    int unsigned n;
    logic [15:0] d [5];
    logic [31:0] word;
    logic        ovf;
  } vec_t;

  vec_t v [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_res(input logic [15:0] d);
    res_valid = 1'b1;
    res_data  = d;
    step();
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  task automatic end_line();
    line_end = 1'b1;
    step();
    line_end = 1'b0;
  endtask

  task automatic wait_req(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!mem_req && n < budget) begin
      step();
      n++;
    end
    chk("wait_req_timeout", {31'd0, mem_req}, 32'd1);
  endtask

  initial begin
    v[0].n = 4; v[0].d = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h0}; v[0].word = 32'h44332211; v[0].ovf = 1'b0;
    v[1].n = 2; v[1].d = '{16'h05, 16'h06, 16'h0, 16'h0, 16'h0};   v[1].word = 32'h00000605; v[1].ovf = 1'b0;
    v[2].n = 5; v[2].d = '{16'h01, 16'h02, 16'h03, 16'h04, 16'h05}; v[2].word = 32'h04030201; v[2].ovf = 1'b1;
    v[4].n = 0; v[4].d = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};     v[4].word = 32'h00000000; v[4].ovf = 1'b0;
    v[3].n = 1; v[3].d = '{16'h0123, 16'h0, 16'h0, 16'h0, 16'h0};
    v[5].n = 3; v[5].d = '{16'h00AB, 16'h0100, 16'h00FF, 16'h0, 16'h0};
    v[3].ovf = 1'b0; v[5].ovf = 1'b0;
`ifdef PE_WB_SAT_EN
    v[3].word = 32'h000000FF;
    v[5].word = 32'h00FFFFAB;
`else
    v[3].word = 32'h00000023;
    v[5].word = 32'h00FF00AB;
`endif

    rst_n = 1'b1; start = 1'b0; res_valid = 1'b0; line_end = 1'b0;
    mem_ack = 1'b0; res_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_adr", {24'd0, mem_adr}, 32'h10);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // no run without start
    send_res(16'h55);
    end_line();
    step(); step(); step();
    chk("nostart_mem_req", {31'd0, mem_req}, 32'd0);

    // table of single-line packing cases, ack held low
    for (int i = 0; i < 6; i++) begin
      pulse_start();
      for (int unsigned k = 0; k < v[i].n; k++) send_res(v[i].d[k]);
      end_line();
      step();
      chk($sformatf("vec%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("vec%0d_mem_adr", i), {24'd0, mem_adr}, 32'h10);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, v[i].word);
      chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, v[i].ovf});
    end

    // res_valid together with line_end: byte included
    pulse_start();
    send_res(16'h77);
    res_valid = 1'b1; res_data = 16'h88; line_end = 1'b1;
    step();
    res_valid = 1'b0; line_end = 1'b0;
    step();
    chk("same_cycle_wdata", mem_wdata, 32'h00008877);

    // start wins over res_valid/line_end
    pulse_start();
    start = 1'b1; res_valid = 1'b1; res_data = 16'h99; line_end = 1'b1;
    step();
    start = 1'b0; res_valid = 1'b0; line_end = 1'b0;
    step(); step();
    chk("start_wins_req", {31'd0, mem_req}, 32'd0);
    chk("start_wins_full", {31'd0, full}, 32'd0);

    // overflow of FIFO with ack low, then drain to done
    pulse_start();
    for (int k = 1; k <= 4; k++) begin
      send_res(16'(16'hA0 + k));
      end_line();
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_ovf", {31'd0, ovf}, 32'd0);
    chk("fill_wdata", mem_wdata, 32'h000000A1);
    send_res(16'hA5);
    end_line();
    chk("drop_ovf", {31'd0, ovf}, 32'd1);
    chk("drop_full", {31'd0, full}, 32'd1);
    chk("drop_wdata_stable", mem_wdata, 32'h000000A1);
    chk("drop_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain%0d_req", k), {31'd0, mem_req}, 32'd1);
      chk($sformatf("drain%0d_adr", k), {24'd0, mem_adr}, 32'h10 + k);
      chk($sformatf("drain%0d_wdata", k), mem_wdata, 32'hA1 + k);
      chk($sformatf("drain%0d_done", k), {31'd0, done}, 32'd0);
      step();
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("done_low", {31'd0, done}, 32'd0);
    step();
    chk("after_done_idle", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // push and pop on a full FIFO in the same cycle
    pulse_start();
    for (int k = 1; k <= 4; k++) begin
      send_res(16'(16'hB0 + k));
      end_line();
    end
    chk("pp_full_before", {31'd0, full}, 32'd1);
    res_valid = 1'b1; res_data = 16'hB5; line_end = 1'b1; mem_ack = 1'b1;
    step();
    res_valid = 1'b0; line_end = 1'b0; mem_ack = 1'b0;
    chk("pp_full_after", {31'd0, full}, 32'd1);
    chk("pp_ovf", {31'd0, ovf}, 32'd0);
    chk("pp_wdata", mem_wdata, 32'h000000B2);
    chk("pp_adr", {24'd0, mem_adr}, 32'h11);

    // start abandons an in-flight request
    pulse_start();
    for (int k = 1; k <= 5; k++) send_res(16'(k));
    end_line();
    send_res(16'h09);
    end_line();
    wait_req(10);
    chk("abandon_ovf_set", {31'd0, ovf}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("abandon_req_pre", {31'd0, mem_req}, 32'd1);
    chk("abandon_adr_pre", {24'd0, mem_adr}, 32'h11);
    chk("abandon_wdata_pre", mem_wdata, 32'h00000009);
    pulse_start();
    chk("abandon_req", {31'd0, mem_req}, 32'd0);
    chk("abandon_full", {31'd0, full}, 32'd0);
    chk("abandon_ovf", {31'd0, ovf}, 32'd0);
    chk("abandon_adr", {24'd0, mem_adr}, 32'h10);
    chk("abandon_wdata", mem_wdata, 32'd0);
    step(); step();
    chk("abandon_stays_idle", {31'd0, mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_writeback.md
PE_WRITEBACK -- requirements
Module: pe_writeback

Interface
REQ-001 Parameter NUM_LINES, default 42, output lines per run; done fires after this many words are written.
REQ-002 Parameter FIFO_DEPTH, default 4, packed-word FIFO entries; power of two, at least 2.
REQ-003 Parameter BASE_ADR, default 0, 8-bit output memory address of line 0.
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port start  in  1  one-cycle pulse; begins a run and clears run state.
REQ-007 Port res_valid  in  1  one PE result is presented this cycle (PE result-buffer load strobe).
REQ-008 Port res_data  in  16  PE accumulator result, unsigned.
REQ-009 Port line_end  in  1  current line is complete (PE memory-write strobe); flush packed word.
REQ-010 Port mem_req  out  1  write request to output memory.
REQ-011 Port mem_adr  out  8  write address.
REQ-012 Port mem_wdata  out  32  packed write data.
REQ-013 Port mem_ack  in  1  memory accepted the write this cycle.
REQ-014 Port full  out  1  FIFO holds FIFO_DEPTH words.
REQ-015 Port ovf  out  1  sticky error: a lane or word was dropped.
REQ-016 Port done  out  1  one-cycle pulse; run finished.

Function
REQ-017 Packer holds 4 byte lanes plus a 3-bit lane count; res_valid writes the byte to lane[count] (lane 0 = bits 7:0) and increments the count.
REQ-018 res_valid with lane count already 4: byte dropped, ovf set.
REQ-019 line_end pushes {lane3..lane0} to the FIFO with unfilled lanes zero, then clears lanes and count.
REQ-020 res_valid and line_end in the same cycle: byte is packed first and included in the pushed word.
REQ-021 line_end while full with no pop that cycle: word dropped, ovf set, packer still cleared.
REQ-022 Simultaneous push and pop on a full FIFO is accepted with no loss.
REQ-023 Writer FSM has states W_IDLE, W_REQ and W_DONE.
REQ-024 W_IDLE: go to W_REQ when the FIFO is non-empty.
REQ-025 W_REQ: mem_req=1, mem_wdata=FIFO head, mem_adr=BASE_ADR+wr_cnt, all held stable until mem_ack.
REQ-026 W_REQ with mem_ack: pop and increment wr_cnt; if the new wr_cnt equals NUM_LINES go to W_DONE, else stay in W_REQ if the FIFO is still non-empty, otherwise go to W_IDLE.
REQ-027 W_DONE: done=1 for one cycle, then go to W_IDLE; further words are written only after the next start.
REQ-028 mem_ack outside W_REQ is ignored.
REQ-029 mem_req is registered: a word pushed at edge N gives mem_req=1 from edge N+1 when the FSM is in W_IDLE; one word per cycle is sustained under continuous ack.
REQ-030 wr_cnt is 8-bit; mem_adr wraps modulo 256.
REQ-031 start in any state: FIFO, packer, wr_cnt and ovf cleared, FSM to W_IDLE next cycle, and any in-flight request abandoned.
REQ-032 start with res_valid or line_end in the same cycle: start wins and the input is discarded.

Reset
REQ-033 rst_n low immediately clears the FSM to W_IDLE, FIFO to empty, packer, wr_cnt and ovf, and drives mem_req=0, mem_adr=BASE_ADR, mem_wdata=0, full=0, done=0.
REQ-034 Reset deassertion takes effect at the next rising clk edge; no run begins without start.

Configuration
REQ-035 Macro PE_WB_SAT_EN defined: a lane byte is 255 when res_data>255, else res_data[7:0].
REQ-036 Macro PE_WB_SAT_EN undefined: a lane byte is res_data[7:0] (truncation).

Verification
REQ-037 Reset, start, res_valid with res_data 0x11, 0x22, 0x33, 0x44, then line_end, mem_ack tied 1 -> one write: mem_adr=BASE_ADR, mem_wdata=0x44332211.
REQ-038 Two results 0x05 and 0x06 then line_end -> mem_wdata=0x00000605; a fifth res_valid on a full line sets ovf=1.
REQ-039 mem_ack held 0, 5 lines pushed with FIFO_DEPTH=4 -> full=1 after 4 words, 5th word dropped, ovf=1, mem_wdata stable while mem_req=1.
REQ-040 res_data=0x0123: with PE_WB_SAT_EN lane=0xFF; without it lane=0x23.
REQ-041 NUM_LINES=3, 3 lines with ack -> addresses BASE_ADR..BASE_ADR+2, done high exactly one cycle after the 3rd ack.
REQ-042 start asserted during W_REQ with ack low -> mem_req=0 next cycle, FIFO empty, ovf=0, wr_cnt=0.
